// File: rtl/alu_issue_stage.sv
// Issue stage in front of the combinational ALU: register file, operand fetch
// with bypass, a registered execute stage and a back-pressured result stage.
module alu_issue_stage #(
  parameter int REG_AW = 4,
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_op,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic              in_use_imm,
  input  logic [IMM_W-1:0]  in_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [5:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [REG_AW-1:0] res_rd,
  output logic [15:0]       stall_cnt
);
  localparam int NREG = 2 ** REG_AW;

  logic [DATA_W-1:0] r_rf [NREG];
  logic              r_e_valid;
  logic [REG_AW-1:0] r_e_rd;

  logic              w_accept;
  logic              w_e_adv;
  logic              w_fire;
  logic [DATA_W-1:0] w_opa;
  logic [DATA_W-1:0] w_opb;

  assign w_accept = !res_valid || res_ready;
  assign w_e_adv  = r_e_valid && w_accept;
  assign in_ready = !r_e_valid || w_accept;
  assign w_fire   = in_valid && in_ready;

  // The result leaving E this edge is not yet in the array, so forward it.
  always_comb begin
    w_opa = '0;
    w_opb = '0;
    if (in_rs != '0) begin
      if (w_e_adv && r_e_rd == in_rs) w_opa = alu_out;
      else                            w_opa = r_rf[in_rs];
    end
    if (in_use_imm) begin
      w_opb = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
    end else if (in_rt != '0) begin
      if (w_e_adv && r_e_rd == in_rt) w_opb = alu_out;
      else                            w_opb = r_rf[in_rt];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_e_valid <= 1'b0;
      r_e_rd    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
    end else if (w_fire) begin
      r_e_valid <= 1'b1;
      r_e_rd    <= in_rd;
      alu_a     <= w_opa;
      alu_b     <= w_opb;
      alu_op    <= in_op;
    end else if (w_e_adv) begin
      r_e_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_rd    <= '0;
      stall_cnt <= '0;
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else begin
      if (w_e_adv) begin
        res_valid <= 1'b1;
        res_data  <= alu_out;
        res_rd    <= r_e_rd;
        if (r_e_rd != '0) r_rf[r_e_rd] <= alu_out;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
      if (r_e_valid && !w_accept && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: supplies a behavioural ALU and checks against a
// sequential-semantics register model plus a result queue.
module tb_alu_issue_stage;
  logic        clk, rst;
  logic        in_valid, in_ready, in_use_imm;
  logic [5:0]  in_op, alu_op;
  logic [3:0]  in_rd, in_rs, in_rt, res_rd;
  logic [15:0] in_imm, stall_cnt;
  logic [31:0] alu_a, alu_b, alu_out, res_data;
  logic        res_valid, res_ready;

  alu_issue_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
    .in_use_imm(in_use_imm), .in_imm(in_imm), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_out(alu_out), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_rd(res_rd),
    .stall_cnt(stall_cnt)
  );

  function automatic logic [31:0] alu_fn(input logic [31:0] a, b, input logic [5:0] op);
    logic [31:0] r;
    case (op[5:4])
      2'd0: r = op[0] ? a - b : a + b;
      2'd1: r = op[0] ? {31'd0, a < b} : {31'd0, $signed(a) < $signed(b)};
      2'd2: case (op[1:0])
              2'd0: r = a & b;
              2'd1: r = a | b;
              2'd2: r = a ^ b;
              default: r = ~(a | b);
            endcase
      default: case (op[1:0])
              2'd0: r = a << b[4:0];
              2'd1: r = a >> b[4:0];
              2'd2: r = $signed(a) >>> b[4:0];
              default: r = (a << b[4:0]) | (a >> ((32 - b[4:0]) & 31));
            endcase
    endcase
    return r;
  endfunction

  assign alu_out = alu_fn(alu_a, alu_b, alu_op);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: architectural registers updated at issue time, plus the
  // expected contents of E and a queue of results waiting in W.
  typedef struct { logic [31:0] d; logic [3:0] rd; } res_t;
  res_t        resq[$];
  logic [31:0] regs [16];
  bit          me_valid;
  logic [31:0] me_a, me_b, me_res;
  logic [5:0]  me_op;
  logic [3:0]  me_rd;
  int          m_stall;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) regs[i] = '0;
    resq.delete();
    me_valid = 0;
    m_stall  = 0;
  endtask

  // Called just after a falling edge; ends just after the next falling edge.
  task automatic step(input bit v, input logic [5:0] op, input logic [3:0] rd, rs, rt,
                      input bit ui, input logic [15:0] imm, input bit rr);
    bit w_full, acc, eadv, rdy, fire;
    logic [31:0] a, b;
    in_valid = v; in_op = op; in_rd = rd; in_rs = rs; in_rt = rt;
    in_use_imm = ui; in_imm = imm; res_ready = rr;
    #1;
    w_full = resq.size() != 0;
    acc    = !w_full || rr;
    eadv   = me_valid && acc;
    rdy    = !me_valid || acc;
    chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    chk("res_valid", {31'd0, res_valid}, {31'd0, w_full});
    if (me_valid) begin
      chk("alu_a", alu_a, me_a);
      chk("alu_b", alu_b, me_b);
      chk("alu_op", {26'd0, alu_op}, {26'd0, me_op});
    end
    if (w_full) begin
      chk("res_data", res_data, resq[0].d);
      chk("res_rd", {28'd0, res_rd}, {28'd0, resq[0].rd});
    end
    fire = v && rdy;
    if (me_valid && !acc && m_stall < 16'hFFFF) m_stall++;
    @(posedge clk);
    if (w_full && rr) void'(resq.pop_front());
    if (eadv) resq.push_back('{d: me_res, rd: me_rd});
    if (fire) begin
      a = (rs == 0) ? 32'd0 : regs[rs];
      b = ui ? {{16{imm[15]}}, imm} : ((rt == 0) ? 32'd0 : regs[rt]);
      me_valid = 1; me_a = a; me_b = b; me_op = op; me_rd = rd;
      me_res = alu_fn(a, b, op);
      if (rd != 0) regs[rd] = me_res;
    end else if (eadv) begin
      me_valid = 0;
    end
    @(negedge clk);
    chk("stall_cnt", {16'd0, stall_cnt}, m_stall[31:0]);
  endtask

  task automatic idle(input bit rr);
    step(0, 6'd0, 4'd0, 4'd0, 4'd0, 0, 16'd0, rr);
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_op = 0; in_rd = 0; in_rs = 0; in_rt = 0;
    in_use_imm = 0; in_imm = 0; res_ready = 1;
    model_reset();
    #2;
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_op", {26'd0, alu_op}, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // ADDI R1 = R0 + 5, then R2 = R1 + R1 back to back (bypass)
    step(1, 6'h00, 4'd1, 4'd0, 4'd0, 1, 16'h0005, 1);
    chk("addi_a", alu_a, 32'd0);
    chk("addi_b", alu_b, 32'd5);
    step(1, 6'h00, 4'd2, 4'd1, 4'd1, 0, 16'h0000, 1);
    chk("byp_a", alu_a, 32'd5);
    chk("byp_b", alu_b, 32'd5);
    chk("res1_data", res_data, 32'd5);
    chk("res1_rd", {28'd0, res_rd}, 32'd1);
    // negative immediate
    step(1, 6'h00, 4'd3, 4'd0, 4'd0, 1, 16'hFFFE, 1);
    chk("res2_data", res_data, 32'd10);
    chk("negimm_b", alu_b, 32'hFFFF_FFFE);
    // write to R0 is dropped; a following R0 read is zero
    step(1, 6'h00, 4'd0, 4'd1, 4'd1, 0, 16'h0000, 1);
    step(1, 6'h00, 4'd4, 4'd0, 4'd0, 0, 16'h0000, 1);
    chk("r0_read_a", alu_a, 32'd0);
    chk("r0_read_b", alu_b, 32'd0);
    idle(1); idle(1);

    // backpressure: fill E and W, hold, then drain
    step(1, 6'h20, 4'd5, 4'd1, 4'd2, 0, 16'h0000, 0);
    step(1, 6'h00, 4'd6, 4'd5, 4'd0, 1, 16'h0100, 0);
    for (int i = 0; i < 4; i++) step(1, 6'h00, 4'd7, 4'd6, 4'd6, 0, 16'h0000, 0);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_stall", {16'd0, stall_cnt}, 32'd4);
    for (int i = 0; i < 4; i++) idle(1);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      logic [5:0] op;
      op = {2'($urandom), 2'b00, 2'($urandom)};
      step($urandom_range(0, 3) != 0, op, 4'($urandom), 4'($urandom), 4'($urandom),
           $urandom_range(0, 1) == 1, 16'($urandom), $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 4; i++) idle(1);

    // asynchronous reset with E and W both occupied
    step(1, 6'h00, 4'd1, 4'd0, 4'd0, 1, 16'h0033, 0);
    step(1, 6'h00, 4'd2, 4'd1, 4'd0, 1, 16'h0001, 0);
    chk("pre_rst_res_valid", {31'd0, res_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_stall", {16'd0, stall_cnt}, 32'd0);
    model_reset();
    in_valid = 0;
    @(negedge clk); rst = 1'b0;
    step(1, 6'h00, 4'd3, 4'd1, 4'd1, 0, 16'h0000, 1);
    chk("post_rst_r1_a", alu_a, 32'd0);
    chk("post_rst_r1_b", alu_b, 32'd0);
    idle(1); idle(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
